led_pattern_scheduler: RTL and testbench

Time-multiplexing controller for up to four LED pattern generators on the DE10 board. It runs a schedule over the enabled generators, each for a fixed dwell time with an optional blank gap between them. It asserts exactly one generator's enable, drives a shared count direction that flips every full pass, and muxes the selected pattern onto the 10 board LEDs. Start, stop, pause and skip come from the push-button/switch layer.

---
 rtl/led_pattern_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: time-multiplexes up to four LED pattern generators,
// each for a fixed dwell with an optional blank gap, under start/stop/skip/pause.
module led_pattern_scheduler #(
  parameter int TICK_BITS = 22,
  parameter int DWELL     = 16,
  parameter int GAP       = 2,
  parameter bit LOOP      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       skip,
  input  logic       pause,
  input  logic [3:0] mask,
  input  logic [9:0] pat0,
  input  logic [9:0] pat1,
  input  logic [9:0] pat2,
  input  logic [9:0] pat3,
  output logic [3:0] pat_en,
  output logic       pat_dir,
  output logic [9:0] leds,
  output logic [1:0] step,
  output logic       busy,
  output logic [7:0] pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  state_t               saved_r, saved_nxt_s;
  logic [TICK_BITS-1:0] div_r, div_nxt_s;
  logic [7:0]           dwell_r, dwell_nxt_s;
  logic [7:0]           gap_r, gap_nxt_s;
  logic [1:0]           step_nxt_s;
  logic                 dir_nxt_s;
  logic [7:0]           pass_nxt_s;
  logic [3:0]           pat_en_nxt_s;
  logic [9:0]           leds_nxt_s;
  logic                 busy_nxt_s;
  logic                 tick_s;
  logic                 adv_s;
  logic                 wrap_s;
  logic [1:0]           next_gen_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // First set mask bit after cur, searching circularly; cur itself is the last candidate.
  function automatic logic [1:0] next_gen(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    next_gen = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) begin
        next_gen = idx;
      end else begin
        next_gen = next_gen;
      end
    end
  endfunction

  // Tick and advance-target decode.
  always_comb begin
    tick_s     = &div_r;
    next_gen_s = next_gen(mask, step);
    wrap_s     = (next_gen_s <= step);
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      saved_r  <= S_RUN;
      div_r    <= '0;
      dwell_r  <= 8'd0;
      gap_r    <= 8'd0;
      step     <= 2'd0;
      pat_dir  <= 1'b1;
      pass_cnt <= 8'd0;
      pat_en   <= 4'd0;
      leds     <= 10'd0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      saved_r  <= saved_nxt_s;
      div_r    <= div_nxt_s;
      dwell_r  <= dwell_nxt_s;
      gap_r    <= gap_nxt_s;
      step     <= step_nxt_s;
      pat_dir  <= dir_nxt_s;
      pass_cnt <= pass_nxt_s;
      pat_en   <= pat_en_nxt_s;
      leds     <= leds_nxt_s;
      busy     <= busy_nxt_s;
    end
  end

  // Next-state logic: command priority stop > skip > pause > start, then advance.
  always_comb begin
    state_nxt_s = state_r;
    saved_nxt_s = saved_r;
    div_nxt_s   = div_r;
    dwell_nxt_s = dwell_r;
    gap_nxt_s   = gap_r;
    step_nxt_s  = step;
    dir_nxt_s   = pat_dir;
    pass_nxt_s  = pass_cnt;
    adv_s       = 1'b0;
    if (stop) begin
      state_nxt_s = S_IDLE;
      div_nxt_s   = '0;
      dwell_nxt_s = 8'd0;
      gap_nxt_s   = 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (mask != 4'd0)) begin
            state_nxt_s = S_RUN;
            step_nxt_s  = next_gen(mask, 2'd3);
            div_nxt_s   = '0;
            dwell_nxt_s = 8'd0;
            gap_nxt_s   = 8'd0;
            dir_nxt_s   = 1'b1;
            pass_nxt_s  = 8'd0;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_RUN, S_GAP: begin
          if (skip) begin
            adv_s = 1'b1;
          end else if (pause) begin
            saved_nxt_s = state_r;
            state_nxt_s = S_PAUSE;
          end else begin
            div_nxt_s = div_r + 1'b1;
            if (!tick_s) begin
              state_nxt_s = state_r;
            end else if (state_r == S_RUN) begin
              if (dwell_r != 8'(DWELL - 1)) begin
                dwell_nxt_s = dwell_r + 8'd1;
              end else if (GAP > 0) begin
                state_nxt_s = S_GAP;
                gap_nxt_s   = 8'd0;
              end else begin
                adv_s = 1'b1;
              end
            end else begin
              if (gap_r == 8'(GAP - 1)) begin
                adv_s = 1'b1;
              end else begin
                gap_nxt_s = gap_r + 8'd1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (pause) begin
            state_nxt_s = S_PAUSE;
          end else begin
            state_nxt_s = saved_r;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase

      // A wrap back to an equal or lower index closes a pass.
      if (adv_s) begin
        div_nxt_s   = '0;
        dwell_nxt_s = 8'd0;
        gap_nxt_s   = 8'd0;
        if (mask == 4'd0) begin
          state_nxt_s = S_IDLE;
        end else begin
          if (wrap_s) begin
            pass_nxt_s = (pass_cnt == 8'd255) ? pass_cnt : pass_cnt + 8'd1;
            dir_nxt_s  = ~pat_dir;
          end else begin
            pass_nxt_s = pass_cnt;
          end
          if (wrap_s && (LOOP == 1'b0)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_RUN;
            step_nxt_s  = next_gen_s;
          end
        end
      end else begin
        step_nxt_s = step_nxt_s;
      end
    end
  end

  // Output values for the next state; PAUSE keeps the last LED image.
  always_comb begin
    pat_en_nxt_s = 4'd0;
    leds_nxt_s   = 10'd0;
    busy_nxt_s   = (state_nxt_s != S_IDLE);
    case (state_nxt_s)
      S_RUN: begin
        pat_en_nxt_s = onehot(step_nxt_s);
        case (step_nxt_s)
          2'd0:    leds_nxt_s = pat0;
          2'd1:    leds_nxt_s = pat1;
          2'd2:    leds_nxt_s = pat2;
          2'd3:    leds_nxt_s = pat3;
          default: leds_nxt_s = 10'd0;
        endcase
      end
      S_PAUSE: begin
        leds_nxt_s = leds;
      end
      S_GAP: begin
        leds_nxt_s = 10'd0;
      end
      default: begin
        leds_nxt_s = 10'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench: a cycle-count reference model predicts every output of a
// LOOP=1 and a LOOP=0 scheduler driven by the same directed and random stimulus.
module tb_led_pattern_scheduler;

  localparam int TB       = 2;
  localparam int DW       = 3;
  localparam int GP       = 1;
  localparam int STEP_CYC = DW * (1 << TB);
  localparam int GAP_CYC  = GP * (1 << TB);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_GAP   = 2;
  localparam int M_PAUSE = 3;

  logic       clk = 1'b0;
  logic       rst, start, stop, skip, pause;
  logic [3:0] mask;
  logic [9:0] pat0, pat1, pat2, pat3;

  logic [3:0] a_en, b_en;
  logic       a_dir, b_dir, a_busy, b_busy;
  logic [9:0] a_leds, b_leds;
  logic [1:0] a_step, b_step;
  logic [7:0] a_pass, b_pass;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         mode;
    int         saved;
    int         t;
    int         step;
    bit         dir;
    int         pass;
    logic [9:0] leds;
    logic [3:0] en;
  } mdl_t;

  mdl_t ma, mb;
  logic [25:0] qa[$];
  logic [25:0] qb[$];

  always #5 clk = ~clk;

  led_pattern_scheduler #(.TICK_BITS(TB), .DWELL(DW), .GAP(GP), .LOOP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip), .pause(pause),
    .mask(mask), .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
    .pat_en(a_en), .pat_dir(a_dir), .leds(a_leds), .step(a_step), .busy(a_busy),
    .pass_cnt(a_pass));

  led_pattern_scheduler #(.TICK_BITS(TB), .DWELL(DW), .GAP(GP), .LOOP(1'b0)) u_dut_once (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip), .pause(pause),
    .mask(mask), .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
    .pat_en(b_en), .pat_dir(b_dir), .leds(b_leds), .step(b_step), .busy(b_busy),
    .pass_cnt(b_pass));

  function automatic logic [9:0] patv(input int s);
    case (s)
      0:       return pat0;
      1:       return pat1;
      2:       return pat2;
      default: return pat3;
    endcase
  endfunction

  // One scheduler edge: elapsed active cycles per step/gap instead of div/dwell counters.
  function automatic mdl_t mstep(input mdl_t m, input bit loop);
    mdl_t r;
    bit   adv;
    int   nxt;
    r   = m;
    adv = 1'b0;
    if (rst) begin
      r.mode = M_IDLE; r.saved = M_RUN; r.t = 0; r.step = 0; r.dir = 1'b1;
      r.pass = 0; r.leds = 10'd0; r.en = 4'd0;
      return r;
    end
    if (stop) begin
      r.mode = M_IDLE; r.leds = 10'd0; r.en = 4'd0;
      return r;
    end
    if (r.mode == M_IDLE) begin
      if (start && mask != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (mask[i]) r.step = i;
        r.mode = M_RUN; r.t = 0; r.dir = 1'b1; r.pass = 0;
      end
    end else if (r.mode == M_PAUSE) begin
      if (!pause) r.mode = r.saved;
    end else begin
      if (skip) adv = 1'b1;
      else if (pause) begin
        r.saved = r.mode; r.mode = M_PAUSE;
      end else begin
        r.t++;
        if (r.mode == M_RUN && r.t == STEP_CYC) begin
          if (GP > 0) begin r.mode = M_GAP; r.t = 0; end
          else adv = 1'b1;
        end else if (r.mode == M_GAP && r.t == GAP_CYC) adv = 1'b1;
      end
    end
    if (adv) begin
      if (mask == 4'd0) r.mode = M_IDLE;
      else begin
        nxt = -1;
        for (int k = 1; k <= 4; k++)
          if (nxt < 0 && mask[(r.step + k) % 4]) nxt = (r.step + k) % 4;
        if (nxt <= r.step) begin
          r.pass = (r.pass < 255) ? r.pass + 1 : 255;
          r.dir  = !r.dir;
        end
        if (nxt <= r.step && !loop) r.mode = M_IDLE;
        else begin r.mode = M_RUN; r.step = nxt; r.t = 0; end
      end
    end
    if (r.mode == M_RUN) begin
      r.en = 4'd1 << r.step; r.leds = patv(r.step);
    end else if (r.mode == M_PAUSE) begin
      r.en = 4'd0;
    end else begin
      r.en = 4'd0; r.leds = 10'd0;
    end
    return r;
  endfunction

  function automatic logic [25:0] pack(input mdl_t m);
    return {m.en, m.dir, m.leds, 2'(m.step), (m.mode != M_IDLE), 8'(m.pass)};
  endfunction

  // Reference model: predict the outputs each edge will produce.
  always @(posedge clk) begin
    ma = mstep(ma, 1'b1);
    mb = mstep(mb, 1'b0);
    qa.push_back(pack(ma));
    qb.push_back(pack(mb));
  end

  // Monitor: compare registered outputs mid-cycle against the queued predictions.
  always @(negedge clk) begin
    logic [25:0] e, g;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {a_en, a_dir, a_leds, a_step, a_busy, a_pass};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL loop_dut t=%0t got en=%h dir=%b leds=%h step=%0d busy=%b pass=%0d exp en=%h dir=%b leds=%h step=%0d busy=%b pass=%0d",
                 $time, g[25:22], g[21], g[20:11], g[10:9], g[8], g[7:0],
                 e[25:22], e[21], e[20:11], e[10:9], e[8], e[7:0]);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {b_en, b_dir, b_leds, b_step, b_busy, b_pass};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL once_dut t=%0t got en=%h dir=%b leds=%h step=%0d busy=%b pass=%0d exp en=%h dir=%b leds=%h step=%0d busy=%b pass=%0d",
                 $time, g[25:22], g[21], g[20:11], g[10:9], g[8], g[7:0],
                 e[25:22], e[21], e[20:11], e[10:9], e[8], e[7:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; skip = 1'b0; pause = 1'b0;
    mask = 4'd0;
    pat0 = 10'h001; pat1 = 10'h002; pat2 = 10'h004; pat3 = 10'h008;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Full pass over 0,1,3 and the wrap back to 0.
    mask = 4'b1011; pulse_start(); cyc(56); pulse_stop(); cyc(2);

    // Single-generator schedule wraps on every advance.
    mask = 4'b0100; pulse_start(); cyc(40); pulse_stop(); cyc(2);

    // Pause after the first tick of step 0.
    mask = 4'b0001; pulse_start(); cyc(4);
    pause = 1'b1; cyc(20); pause = 1'b0; cyc(20); pulse_stop(); cyc(2);

    // Skip mid-step 1, then skip+stop together.
    mask = 4'b0011; pulse_start(); cyc(22);
    skip = 1'b1; cyc(1); skip = 1'b0; cyc(5);
    skip = 1'b1; stop = 1'b1; cyc(1); skip = 1'b0; stop = 1'b0; cyc(3);

    // Single pass on the LOOP=0 instance, then start with an empty mask.
    mask = 4'b0001; pulse_start(); cyc(20);
    mask = 4'b0000; pulse_start(); cyc(8); pulse_stop(); cyc(2);

    // Reset during a gap, then a normal restart.
    mask = 4'b1011; pulse_start(); cyc(14);
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);
    pulse_start(); cyc(30);

    // Random commands, mask and pattern changes.
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 63) == 0);
      skip  = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        pat0 = 10'($urandom); pat1 = 10'($urandom);
        pat2 = 10'($urandom); pat3 = 10'($urandom);
      end
      cyc(1);
    end
    start = 1'b0; stop = 1'b0; skip = 1'b0; rst = 1'b0; pause = 1'b0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
